uart_byte_packer: RTL and testbench

- Parametrised successor to the fixed 8-to-24 UART byte register.
- Packs a stream of received UART bytes into words of BYTES_PER_WORD bytes, right-justified in a DOUT_WIDTH bus, with a byte count per word.
- Partial words are emitted on an explicit flush or after an idle timeout.
- Completed words are queued in a small output FIFO, so the host side can lag the UART by up to OUT_DEPTH words.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_packer_fifo.sv | 73 +++++++
 rtl/uart_byte_packer.sv | 159 +++++++++++++++
 tb/tb_uart_byte_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================
// Package  : uart_pkg
// Shared state encoding and width helper for the byte packer.
// Revision : 1.0
// ============================================================
package uart_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    HOLD    = 2'd2
  } packer_state_t;

  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_packer_fifo.sv
`default_nettype none
// ============================================================
// Module   : uart_packer_fifo
// Show-ahead synchronous FIFO; push and pop may share a cycle.
// Revision : 1.0
// ============================================================
module uart_packer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_byte_packer.sv
`default_nettype none
// ============================================================
// Module   : uart_byte_packer
// Packs UART bytes into right-justified words queued for the host.
// Revision : 1.0
// ============================================================
module uart_byte_packer
  import uart_pkg::*;
#(
  parameter int BYTES_PER_WORD = 3,
  parameter int DOUT_WIDTH     = 32,
  parameter int OUT_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wren,
  input  logic [7:0]                          din,
  output logic                                in_ready,
  input  logic                                flush,
  input  logic                                rden,
  output logic [DOUT_WIDTH-1:0]               dout,
  output logic [clog2p1(BYTES_PER_WORD)-1:0]  valid_bytes,
  output logic                                out_valid,
  output logic                                overflow
);

  localparam int CW     = clog2p1(BYTES_PER_WORD);
  localparam int ACC_W  = 8 * BYTES_PER_WORD;
  localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int FC_W   = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic [DOUT_WIDTH-1:0] data;
    logic [CW-1:0]         nbytes;
  } packed_word_t;

  packer_state_t     state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              pending_q, pending_d;
  logic              overflow_q, overflow_d;

  logic              accept;
  logic              space;
  logic              timeout_hit;
  logic              flush_req;
  logic              push;
  packed_word_t      push_word;
  packed_word_t      head;
  logic [FC_W-1:0]   fifo_count;

  assign in_ready    = (state_q != HOLD);
  assign accept      = wren && in_ready;
  assign out_valid   = (fifo_count != '0);
  // A pop in the same cycle frees the slot the new word needs.
  assign space       = (fifo_count < FC_W'(OUT_DEPTH)) || (rden && out_valid);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == FILLING) && !accept &&
                       (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign flush_req   = flush || timeout_hit || pending_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    idle_d     = idle_q;
    pending_d  = pending_q;
    overflow_d = overflow_q || (wren && !in_ready);
    push       = 1'b0;

    if (accept) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (count_q == CW'(i)) begin
          acc_d[8*i +: 8] = din;
        end
      end
      count_d = count_q + CW'(1);
      idle_d  = '0;
    end else if ((state_q == FILLING) && (idle_q != IDLE_W'(TIMEOUT_CYCLES))) begin
      idle_d = idle_q + IDLE_W'(1);
    end

    push_word.data   = DOUT_WIDTH'(acc_d);
    push_word.nbytes = count_d;

    case (state_q)
      HOLD: begin
        if (space) begin
          push = 1'b1;
        end
      end
      default: begin
        if (count_d == CW'(BYTES_PER_WORD)) begin
          if (space) begin
            push = 1'b1;
          end else begin
            state_d   = HOLD;
            pending_d = 1'b0;
          end
        end else if (flush_req && (count_d != '0)) begin
          if (space) begin
            push = 1'b1;
          end else begin
            state_d   = FILLING;
            pending_d = 1'b1;
          end
        end else if (count_d != '0) begin
          state_d = FILLING;
        end
      end
    endcase

    if (push) begin
      state_d   = EMPTY;
      count_d   = '0;
      acc_d     = '0;
      idle_d    = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      count_q    <= '0;
      acc_q      <= '0;
      idle_q     <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      idle_q     <= idle_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  uart_packer_fifo #(
    .WIDTH ($bits(packed_word_t)),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (rden),
    .head_data (head),
    .count     (fifo_count)
  );

  assign dout        = out_valid ? head.data   : '0;
  assign valid_bytes = out_valid ? head.nbytes : '0;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_packer.sv
`default_nettype none
// ============================================================
// Module   : tb_uart_byte_packer
// Directed and random stimulus against a queue-based packer model.
// Revision : 1.0
// ============================================================
module tb_uart_byte_packer;

  localparam int BPW   = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int TMO   = 16;
  localparam int CW    = 2;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          wren  = 1'b0;
  logic [7:0]    din   = 8'h00;
  logic          flush = 1'b0;
  logic          rden  = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dout;
  logic [CW-1:0] valid_bytes;
  logic          out_valid;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_byte_packer #(
    .BYTES_PER_WORD (BPW),
    .DOUT_WIDTH     (DW),
    .OUT_DEPTH      (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wren        (wren),
    .din         (din),
    .in_ready    (in_ready),
    .flush       (flush),
    .rden        (rden),
    .dout        (dout),
    .valid_bytes (valid_bytes),
    .out_valid   (out_valid),
    .overflow    (overflow)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            nbytes;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_cur[$];
  int         m_fifo_n = 0;
  bit         m_held   = 1'b0;
  bit         m_pend   = 1'b0;
  bit         m_ovf    = 1'b0;
  int         m_idle   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Word assembled from the pending byte list: first byte in the lowest lane.
  function automatic void m_push();
    exp_t e;
    e.data = '0;
    for (int i = 0; i < m_cur.size(); i++) begin
      e.data = e.data | (DW'(m_cur[i]) << (8 * i));
    end
    e.nbytes = m_cur.size();
    exp_q.push_back(e);
    m_fifo_n++;
    m_cur.delete();
    m_held = 1'b0;
    m_pend = 1'b0;
    m_idle = 0;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      exp_q.delete();
      m_cur.delete();
      m_fifo_n = 0;
      m_held   = 1'b0;
      m_pend   = 1'b0;
      m_ovf    = 1'b0;
      m_idle   = 0;
    end else begin : model_step
      bit space;
      bit tmo;
      space = (m_fifo_n < DEPTH) || (rden && (m_fifo_n > 0));
      if (rden && (m_fifo_n > 0)) m_fifo_n--;
      if (m_held) begin
        if (wren) m_ovf = 1'b1;
        if (space) m_push();
      end else begin
        tmo = !wren && (m_cur.size() > 0) && (m_idle + 1 == TMO);
        if (wren) begin
          m_cur.push_back(din);
          m_idle = 0;
        end else if (m_cur.size() > 0) begin
          m_idle++;
        end
        if (m_cur.size() == BPW) begin
          if (space) m_push();
          else begin
            m_held = 1'b1;
            m_pend = 1'b0;
          end
        end else if ((m_cur.size() > 0) && (flush || tmo || m_pend)) begin
          if (space) m_push();
          else m_pend = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("in_ready", in_ready, !m_held);
    check("out_valid", out_valid, m_fifo_n > 0);
    check("overflow", overflow, m_ovf);
    if (out_valid) begin
      check("word_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check("dout", dout, exp_q[0].data);
        check("valid_bytes", valid_bytes, exp_q[0].nbytes);
        if (rden) void'(exp_q.pop_front());
      end
    end else begin
      check("dout_when_empty", dout, 0);
      check("valid_bytes_when_empty", valid_bytes, 0);
    end
  end

  task automatic step(input bit w, input logic [7:0] d, input bit f, input bit r);
    wren  = w;
    din   = d;
    flush = f;
    rden  = r;
    @(posedge clk);
    #1;
    wren  = 1'b0;
    flush = 1'b0;
    rden  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (out_valid && (guard < 50)) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      guard++;
    end
    check("drain_within_bound", out_valid, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_dout", dout, 0);
    check("reset_overflow", overflow, 0);

    // Full word on consecutive writes
    step(1'b1, 8'hAB, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'hEF, 1'b0, 1'b0);
    check("t1_out_valid", out_valid, 1);
    check("t1_dout", dout, 32'h00EF01AB);
    check("t1_valid_bytes", valid_bytes, 3);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t1_after_read_valid", out_valid, 0);
    check("t1_after_read_dout", dout, 0);

    // Explicit flush, separate and on the write edge
    step(1'b1, 8'h01, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2a_dout", dout, 32'h00000001);
    check("t2a_valid_bytes", valid_bytes, 1);
    drain();
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b1, 1'b0);
    check("t2b_dout", dout, 32'h00000201);
    check("t2b_valid_bytes", valid_bytes, 2);
    drain();

    // Idle timeout, and a write that restarts the idle count
    step(1'b1, 8'h55, 1'b0, 1'b0);
    idle(TMO - 1);
    check("t3_no_early_flush", out_valid, 0);
    idle(1);
    check("t3_timeout_valid", out_valid, 1);
    check("t3_timeout_dout", dout, 32'h00000055);
    drain();
    step(1'b1, 8'h66, 1'b0, 1'b0);
    idle(TMO - 1);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    idle(TMO - 1);
    check("t3b_no_flush", out_valid, 0);
    idle(1);
    check("t3b_dout", dout, 32'h00007766);
    check("t3b_valid_bytes", valid_bytes, 2);
    drain();

    // Backpressure, HOLD and dropped byte
    for (int b = 1; b <= 9; b++) step(1'b1, 8'(b), 1'b0, 1'b0);
    check("t4_hold_in_ready", in_ready, 0);
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    check("t4_overflow", overflow, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_released_in_ready", in_ready, 1);
    check("t4_next_head", dout, 32'h00060504);
    drain();

    // Asynchronous reset mid-word
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_overflow", overflow, 0);
    check("t5_async_in_ready", in_ready, 1);
    check("t5_async_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    check("t5_dout", dout, 32'h00554433);
    check("t5_valid_bytes", valid_bytes, 3);
    drain();

    // Pop and push on the same edge with the FIFO full
    for (int b = 'h61; b <= 'h68; b++) step(1'b1, 8'(b), 1'b0, 1'b0);
    step(1'b1, 8'h69, 1'b0, 1'b1);
    check("t6_in_ready", in_ready, 1);
    check("t6_head", dout, 32'h00666564);
    drain();

    // Random traffic with occasional idle gaps to reach the timeout
    for (int blk = 0; blk < 150; blk++) begin
      for (int k = 0; k < 20; k++) begin
        step($urandom_range(0, 99) < 60, 8'($urandom_range(0, 255)),
             $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 40);
      end
      if ($urandom_range(0, 2) == 0) idle(TMO + 2);
    end
    idle(TMO + 2);
    drain();
    idle(2);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
